// File: rtl/mem_bank_resp.sv
// rtl/mem_bank_resp.sv - four-bank interleaved memory responder, 2-cycle read latency
// Optional misaligned-address rejection: MEMRESP_ALIGN_CHK_EN
module mem_bank_resp #(
  parameter int ADDR_W    = 16,
  parameter int BANK_BUSY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [15:0]       data_out,
  output logic              rd_valid,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int IDX_W = ADDR_W - 1;
  localparam logic [1:0] BUSY_LOAD = 2'(BANK_BUSY - 1);

  logic [1:0]       cnt_q [4];
  logic [1:0]       cnt_d [4];
  logic [15:0]      mem_q [2**IDX_W];
  logic             v1_q, v1_d, v2_q, v2_d;
  logic [15:0]      d1_q, d1_d, d2_q, d2_d;

  logic             req;
  logic             misalign;
  logic             accept;
  logic [1:0]       bank;
  logic [IDX_W-1:0] idx;

`ifdef MEMRESP_ALIGN_CHK_EN
  assign misalign = addr[0];
`else
  logic addr_lsb_unused;
  assign addr_lsb_unused = addr[0];
  assign misalign = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      busy[i] = (cnt_q[i] != 2'd0);
    end
  end

  always_comb begin
    req    = rd ^ wr;
    bank   = addr[2:1];
    idx    = {bank, addr[ADDR_W-1:3]};
    err    = (rd & wr) | (req & misalign);
    stall  = req & ~err & busy[bank];
    accept = req & ~err & ~busy[bank];
  end

  // Counters count down to idle; an accept reloads only the addressed bank.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != 2'd0) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
      if (accept && (bank == 2'(i))) begin
        cnt_d[i] = BUSY_LOAD;
      end
    end
  end

  always_comb begin
    v1_d     = accept & rd;
    d1_d     = mem_q[idx];
    v2_d     = v1_q;
    d2_d     = d1_q;
    rd_valid = v2_q;
    data_out = v2_q ? d2_q : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 2'd0;
      end
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      d1_q <= 16'h0000;
      d2_q <= 16'h0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      v1_q <= v1_d;
      v2_q <= v2_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem_q[idx] <= data_in;
    end
  end

endmodule

// File: tb/tb_mem_bank_resp.sv
// tb/tb_mem_bank_resp.sv - directed self-checking bench for mem_bank_resp
module tb_mem_bank_resp;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  mem_bank_resp #(.ADDR_W(16), .BANK_BUSY(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then drive a new request.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; addr = a; data_in = d;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    sample();
    check("reset_busy", {12'h0, busy}, 16'h0000);
    check("reset_rd_valid", {15'h0, rd_valid}, 16'h0000);
    check("reset_data_out", data_out, 16'h0000);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    sample();
    check("post_reset_busy", {12'h0, busy}, 16'h0000);
    check("post_reset_stall", {15'h0, stall}, 16'h0000);
    check("post_reset_err", {15'h0, err}, 16'h0000);
    check("post_reset_rd_valid", {15'h0, rd_valid}, 16'h0000);
    next_cycle();

    // Write then read back: N = write, N+1 conflicting read stalls, N+4 read accepted
    drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    sample();
    check("wr_beef_stall", {15'h0, stall}, 16'h0000);
    check("wr_beef_err", {15'h0, err}, 16'h0000);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    sample();
    check("wr_beef_busy_n1", {12'h0, busy}, 16'h0001);
    check("raw_stall_n1", {15'h0, stall}, 16'h0001);
    next_cycle();
    next_cycle();
    sample();
    check("raw_stall_n3", {15'h0, stall}, 16'h0001);
    next_cycle();
    sample();
    check("raw_accept_n4", {15'h0, stall}, 16'h0000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    sample();
    check("raw_rd_valid_n5", {15'h0, rd_valid}, 16'h0000);
    check("raw_data_out_idle", data_out, 16'h0000);
    next_cycle();
    sample();
    check("raw_rd_valid_n6", {15'h0, rd_valid}, 16'h0001);
    check("raw_data_n6", data_out, 16'hBEEF);
    next_cycle();
    idle(4);

    // Line fill: preload four banks back to back, then read them back to back
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'h1000 + 16'(2 * i), 16'h00A0 + 16'(i));
      sample();
      check($sformatf("fill_wr_stall_%0d", i), {15'h0, stall}, 16'h0000);
      next_cycle();
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 1'b0, 16'h1000 + 16'(2 * i), 16'h0000);
      else       drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      sample();
      check($sformatf("fill_rd_stall_%0d", i), {15'h0, stall}, 16'h0000);
      if (i >= 2) begin
        check($sformatf("fill_rd_valid_%0d", i), {15'h0, rd_valid}, 16'h0001);
        check($sformatf("fill_rd_data_%0d", i), data_out, 16'h00A0 + 16'(i - 2));
      end else begin
        check($sformatf("fill_rd_valid_%0d", i), {15'h0, rd_valid}, 16'h0000);
      end
      next_cycle();
    end

    // Bank conflict: read 0x0020 then hold read 0x0028 (same bank 0)
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    sample();
    check("conf_first_stall", {15'h0, stall}, 16'h0000);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0028, 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      sample();
      check($sformatf("conf_stall_n%0d", i), {15'h0, stall}, (i < 4) ? 16'h0001 : 16'h0000);
      if (i == 2) check("conf_first_rd_valid", {15'h0, rd_valid}, 16'h0001);
      if (i == 3) check("conf_no_extra_valid", {15'h0, rd_valid}, 16'h0000);
      next_cycle();
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    sample();
    check("conf_rd_valid_n5", {15'h0, rd_valid}, 16'h0000);
    next_cycle();
    sample();
    check("conf_rd_valid_n6", {15'h0, rd_valid}, 16'h0001);
    next_cycle();
    idle(4);

    // Illegal rd&wr: err, no busy change, no read data
    drive(1'b1, 1'b1, 16'h0030, 16'h5555);
    sample();
    check("illegal_err", {15'h0, err}, 16'h0001);
    check("illegal_stall", {15'h0, stall}, 16'h0000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    sample();
    check("illegal_busy", {12'h0, busy}, 16'h0000);
    check("idle_err", {15'h0, err}, 16'h0000);
    next_cycle();
    sample();
    check("illegal_no_rd_valid", {15'h0, rd_valid}, 16'h0000);
    next_cycle();

    // Misaligned write to 0x0011 aliases 0x0010 unless alignment checking is built in
    drive(1'b0, 1'b1, 16'h0011, 16'h1234);
    sample();
`ifdef MEMRESP_ALIGN_CHK_EN
    check("misalign_err", {15'h0, err}, 16'h0001);
`else
    check("misalign_err", {15'h0, err}, 16'h0000);
`endif
    next_cycle();
    idle(4);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    sample();
    check("misalign_rb_stall", {15'h0, stall}, 16'h0000);
    next_cycle();
    idle(1);
    sample();
    check("misalign_rb_valid", {15'h0, rd_valid}, 16'h0001);
`ifdef MEMRESP_ALIGN_CHK_EN
    check("misalign_rb_data", data_out, 16'hBEEF);
`else
    check("misalign_rb_data", data_out, 16'h1234);
`endif
    next_cycle();
    idle(4);

    // Reset in the cycle after a read is accepted discards it
    drive(1'b1, 1'b0, 16'h1002, 16'h0000);
    sample();
    check("rstmid_accept", {15'h0, stall}, 16'h0000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    sample();
    check("rstmid_busy_in_reset", {12'h0, busy}, 16'h0000);
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("rstmid_no_valid_%0d", i), {15'h0, rd_valid}, 16'h0000);
      check($sformatf("rstmid_busy_%0d", i), {12'h0, busy}, 16'h0000);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
